// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;
  typedef enum logic [1:0] {IFS_IDLE, IFS_REQ, IFS_LOAD} ifetch_state_e;
  localparam logic [15:0] IFETCH_RESET_PC = 16'h0000;
endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read port: req/addr out, ack/rdata back.
interface ifetch_if;
  logic        mem_req_out;
  logic [15:0] mem_addr_out;
  logic        mem_ack_in;
  logic [15:0] mem_rdata_in;

  modport master (output mem_req_out, output mem_addr_out,
                  input  mem_ack_in,  input  mem_rdata_in);
  modport slave  (input  mem_req_out, input  mem_addr_out,
                  output mem_ack_in,  output mem_rdata_in);
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, reads words over the memory handshake
// and strobes them into the IR. Redirects may arrive at any time.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = IFETCH_RESET_PC,
  parameter logic [15:0] PC_STEP  = 16'd1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_in,
  input  logic        pc_load_in,
  input  logic [15:0] pc_in,
  ifetch_if.master    mem,
  output logic [15:0] ins_out,
  output logic        il_out,
  output logic [15:0] pc_out,
  output logic        busy_out,
  output logic        err_out
);

  ifetch_state_e state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   ins_q, ins_d;
  logic          err_q, err_d;
  logic          flush_q, flush_d;
  logic [7:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFS_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      ins_q   <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ins_q   <= ins_d;
      err_q   <= err_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_load_in ? pc_in : pc_q;
    addr_d  = addr_q;
    ins_d   = ins_q;
    err_d   = err_q;
    flush_d = flush_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IFS_IDLE: begin
        if (fetch_in) begin
          state_d = IFS_REQ;
          addr_d  = pc_load_in ? pc_in : pc_q;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      IFS_REQ: begin
        if (mem.mem_ack_in) begin
          if (flush_q || pc_load_in) begin
            // Stale data: drop it and re-issue at the (possibly new) PC.
            flush_d = 1'b0;
            addr_d  = pc_d;
            cnt_d   = '0;
          end else begin
            ins_d   = mem.mem_rdata_in;
            pc_d    = pc_q + PC_STEP;
            state_d = IFS_LOAD;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = IFS_IDLE;
          err_d   = 1'b1;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (pc_load_in) flush_d = 1'b1;
        end
      end
      IFS_LOAD: state_d = IFS_IDLE;
      default:  state_d = IFS_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req_out  = (state_q == IFS_REQ);
    mem.mem_addr_out = addr_q;
    il_out           = (state_q == IFS_LOAD);
    busy_out         = (state_q != IFS_IDLE);
    ins_out          = ins_q;
    pc_out           = pc_q;
    err_out          = err_q;
  end

endmodule
